// File: rtl/idct8_recon_stage.sv
// IDCT8 reconstruction stage: rounding shift, prediction add, pixel clip and an output row FIFO.
// Optional macro IDCT8_RECON_BLOCK_CNT_EN adds a 16-bit count of completed 8x8 blocks.
module idct8_recon_stage #(
    parameter int DATA_W     = 25,
    parameter int SHIFT      = 12,
    parameter int BIT_DEPTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        res_in_1,
    input  logic [DATA_W-1:0]        res_in_2,
    input  logic [DATA_W-1:0]        res_in_3,
    input  logic [DATA_W-1:0]        res_in_4,
    input  logic [DATA_W-1:0]        res_in_5,
    input  logic [DATA_W-1:0]        res_in_6,
    input  logic [DATA_W-1:0]        res_in_7,
    input  logic [DATA_W-1:0]        res_in_8,
    input  logic [8*BIT_DEPTH-1:0]   pred_in,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [8*BIT_DEPTH-1:0]   pix_out,
    output logic [2:0]               out_row,
    output logic                     out_last,
    output logic                     overflow,
    output logic                     busy
`ifdef IDCT8_RECON_BLOCK_CNT_EN
    ,
    output logic [15:0]              block_cnt
`endif
);

    localparam int R_W = DATA_W + 1 - SHIFT;
    localparam int S_W = R_W + BIT_DEPTH + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int E_W = 8*BIT_DEPTH + 4;
    localparam logic signed [DATA_W:0]  RND     = {{DATA_W{1'b0}}, 1'b1} << (SHIFT-1);
    localparam logic signed [S_W-1:0]   PIX_MAX = S_W'((1 << BIT_DEPTH) - 1);
    localparam logic [AW:0]             FULL_N  = (AW+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0]        res_lane [8];
    logic signed [R_W-1:0]    r_next   [8];
    logic signed [R_W-1:0]    r1       [8];
    logic [8*BIT_DEPTH-1:0]   pred1;
    logic [2:0]               row1;
    logic [2:0]               row_cnt;
    logic                     v1;
    logic [8*BIT_DEPTH-1:0]   pix_next;

    logic [E_W-1:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [AW:0]              count;
    logic                     full;
    logic                     pop;
    logic                     wr_en;

    assign res_lane[0] = res_in_1;
    assign res_lane[1] = res_in_2;
    assign res_lane[2] = res_in_3;
    assign res_lane[3] = res_in_4;
    assign res_lane[4] = res_in_5;
    assign res_lane[5] = res_in_6;
    assign res_lane[6] = res_in_7;
    assign res_lane[7] = res_in_8;

    // One extra bit keeps the rounding add from wrapping at the residual extremes.
    always_comb begin
        logic signed [DATA_W:0] rsum;
        rsum = '0;
        for (int k = 0; k < 8; k++) begin
            rsum      = $signed({res_lane[k][DATA_W-1], res_lane[k]}) + RND;
            r_next[k] = R_W'(rsum >>> SHIFT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1      <= 1'b0;
            pred1   <= '0;
            row1    <= '0;
            row_cnt <= '0;
            for (int k = 0; k < 8; k++) r1[k] <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                for (int k = 0; k < 8; k++) r1[k] <= r_next[k];
                pred1   <= pred_in;
                row1    <= row_cnt;
                row_cnt <= row_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        logic signed [S_W-1:0] s;
        s        = '0;
        pix_next = '0;
        for (int k = 0; k < 8; k++) begin
            s = {{(S_W-R_W){r1[k][R_W-1]}}, r1[k]}
              + {{(S_W-BIT_DEPTH){1'b0}}, pred1[k*BIT_DEPTH +: BIT_DEPTH]};
            if (s[S_W-1])
                pix_next[k*BIT_DEPTH +: BIT_DEPTH] = '0;
            else if (s > PIX_MAX)
                pix_next[k*BIT_DEPTH +: BIT_DEPTH] = '1;
            else
                pix_next[k*BIT_DEPTH +: BIT_DEPTH] = s[BIT_DEPTH-1:0];
        end
    end

    // Output handshake: a row transfers on a rising edge where out_valid && out_ready;
    // the head fields hold steady while out_valid && !out_ready. The input side has no
    // ready, so a write into a full FIFO without a same-edge pop is dropped and flagged.
    assign out_valid = (count != '0);
    assign full      = (count == FULL_N);
    assign pop       = out_valid && out_ready;
    assign wr_en     = v1 && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {pix_next, row1, (row1 == 3'd7)};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
            if (v1 && full && !pop) overflow <= 1'b1;
        end
    end

    // Head fields read zero when empty so nothing stale leaks out after reset.
    assign {pix_out, out_row, out_last} = out_valid ? mem[rd_ptr] : '0;

    // Stage 2 writes straight into the FIFO, so its valid is carried by out_valid.
    assign busy = v1 | out_valid;

`ifdef IDCT8_RECON_BLOCK_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)               block_cnt <= '0;
        else if (pop && out_last) block_cnt <= block_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_idct8_recon_stage.sv
// Directed + random bench for idct8_recon_stage with an expected-row queue.
module tb_idct8_recon_stage;
    localparam int SHIFT = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [24:0] res [8];
    logic [63:0] pred_in = '0;
    logic        out_valid;
    logic [63:0] pix_out;
    logic [2:0]  out_row;
    logic        out_last;
    logic        overflow;
    logic        busy;
`ifdef IDCT8_RECON_BLOCK_CNT_EN
    logic [15:0] block_cnt;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_last = 0;
    logic [67:0] exp_q[$];
    logic [67:0] mon_exp;
    logic [2:0]  tb_row = '0;

    idct8_recon_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .res_in_1(res[0]), .res_in_2(res[1]), .res_in_3(res[2]), .res_in_4(res[3]),
        .res_in_5(res[4]), .res_in_6(res[5]), .res_in_7(res[6]), .res_in_8(res[7]),
        .pred_in(pred_in), .out_ready(out_ready), .out_valid(out_valid),
        .pix_out(pix_out), .out_row(out_row), .out_last(out_last),
        .overflow(overflow), .busy(busy)
`ifdef IDCT8_RECON_BLOCK_CNT_EN
        , .block_cnt(block_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] recon(input logic signed [24:0] rv, input logic [7:0] p);
        longint r;
        r = (longint'(rv) + 64'sd2048) >>> SHIFT;
        r = r + longint'({56'd0, p});
        if (r < 0)   return 8'd0;
        if (r > 255) return 8'd255;
        return r[7:0];
    endfunction

    function automatic logic [199:0] rep(input logic [24:0] v);
        return {8{v}};
    endfunction

    function automatic logic [199:0] rnd_res();
        logic [199:0] rf;
        logic [24:0]  v;
        rf = '0;
        for (int k = 0; k < 8; k++) begin
            v = 25'($urandom_range(0, 2097152)) - 25'd1048576;
            rf[k*25 +: 25] = v;
        end
        return rf;
    endfunction

    function automatic logic [63:0] rnd_pred();
        return {$urandom, $urandom};
    endfunction

    // Called at posedge+1; returns at the next posedge+1 with in_valid dropped.
    task automatic push(input logic [199:0] rf, input logic [63:0] pf, input bit keep);
        logic [63:0] ep;
        ep = '0;
        for (int k = 0; k < 8; k++) begin
            res[k] = rf[k*25 +: 25];
            ep[k*8 +: 8] = recon(rf[k*25 +: 25], pf[k*8 +: 8]);
        end
        pred_in  = pf;
        in_valid = 1'b1;
        if (keep) exp_q.push_back({ep, tb_row, (tb_row == 3'd7)});
        tb_row = tb_row + 3'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk); #2;
        reset    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        tb_row = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, {busy, 32'(exp_q.size())}, '0);
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            if (out_last) n_last++;
            chk("row_out", {pix_out, out_row, out_last}, mon_exp);
        end
    end

    initial begin
        for (int k = 0; k < 8; k++) res[k] = '0;
        apply_reset();

        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_pix", pix_out, 0);
        chk("rst_tag", {out_row, out_last}, 0);
        chk("rst_flags", {overflow, busy}, 0);
        @(posedge clk); #1;

        // DC rounding and two-edge latency
        out_ready = 1'b1;
        push(rep(25'd20480), {8{8'd100}}, 1'b1);
        @(negedge clk);
        chk("lat_edge1", {busy, out_valid}, 2'b10);
        @(negedge clk);
        chk("lat_edge2", out_valid, 1);
        chk("dc_105", pix_out, {8{8'd105}});
        @(posedge clk); #1;
        push(rep(25'd4096), {8{8'd100}}, 1'b1);

        // Negative, clip and mixed lanes
        push(rep(-25'sd6144), {8{8'd0}}, 1'b1);
        push(rep(-25'sd2048), {8{8'd37}}, 1'b1);
        push(rep(25'd4000000), {8{8'd200}}, 1'b1);
        push({25'sd4000000, -25'sd6144, 25'sd20480, 25'sd4096,
              -25'sd2048, 25'sd0, 25'h1000000, 25'h0FFFFFF},
             {8'd200, 8'd0, 8'd100, 8'd100, 8'd37, 8'd255, 8'd255, 8'd0}, 1'b1);
        for (int i = 0; i < 8; i++) push(rnd_res(), rnd_pred(), 1'b1);
        drain("drain_basic");

        // Reset with three rows buffered
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(rnd_res(), rnd_pred(), 1'b1);
        @(posedge clk); #1;
        chk("mid_buffered", out_valid, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {out_valid, busy, overflow}, 0);
        chk("mid_rst_head", {pix_out, out_row, out_last}, 0);
        exp_q.delete();
        tb_row = '0;
        @(posedge clk); #1 reset = 1'b1;
        out_ready = 1'b1;
        push(rnd_res(), rnd_pred(), 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_row", {out_valid, out_row}, {1'b1, 3'd0});
        @(posedge clk); #1;
        drain("drain_mid");

        // Backpressure and overflow
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(rnd_res(), rnd_pred(), (i < 4));
            if (i == 4) chk("ovf_before", overflow, 0);
            if (i == 5) chk("ovf_set", overflow, 1);
        end
        idle(2);
        chk("ovf_full", {out_valid, overflow}, 2'b11);
        out_ready = 1'b1;
        idle(6);
        chk("ovf_drained", {out_valid, 32'(exp_q.size())}, 0);
        chk("ovf_sticky", overflow, 1);

        // Push and pop on the same edge while full
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i == 5) out_ready = 1'b1;
            push(rnd_res(), rnd_pred(), 1'b1);
        end
        drain("sim_drain");
        chk("sim_no_ovf", overflow, 0);

        // Block tagging over two blocks
        apply_reset();
        n_last = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) push(rnd_res(), rnd_pred(), 1'b1);
        drain("blk_drain");
        chk("blk_lasts", 32'(n_last), 32'd2);
`ifdef IDCT8_RECON_BLOCK_CNT_EN
        chk("blk_cnt", block_cnt, 16'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
